lpr_boundary_detect: RTL and testbench

// - Producer of the plate-boundary interface consumed by the video overlay stage: scans a binarized

---
 rtl/lpr_pkg.sv | 29 ++
 rtl/lpr_row_accum.sv | 66 ++++++
 rtl/lpr_boundary_detect.sv | 186 ++++++++++++++++++
 tb/tb_lpr_boundary_detect.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lpr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpr_pkg : shared widths, FSM states and box type for plate boundary detect |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lpr_pkg;

    localparam int COORD_W = 12;

    typedef enum logic [2:0] {
        WAIT_VS    = 3'd0,
        SCAN       = 3'd1,
        ROW_END    = 3'd2,
        FRAME_EVAL = 3'd3,
        LATCH      = 3'd4
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] h_l;
        logic [COORD_W-1:0] h_r;
        logic [COORD_W-1:0] v_l;
        logic [COORD_W-1:0] v_r;
    } box_t;

    // An all-zero box draws nothing in the overlay stage.
    localparam box_t BOX_CLEAR = '0;

endpackage
`default_nettype wire

// File: rtl/lpr_row_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpr_row_accum : per-line candidate count and min/max column, with qualify  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lpr_row_accum
    import lpr_pkg::*;
#(
    parameter int ROW_MIN = 20
)
(
    input  logic               pixelclk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [COORD_W-1:0] hcount_i,
    output logic [COORD_W-1:0] min_o,
    output logic [COORD_W-1:0] max_o,
    output logic               qual_o
);

    localparam logic [COORD_W-1:0] c_ROW_MIN = COORD_W'(ROW_MIN);

    logic [COORD_W-1:0] cnt_q, cnt_d;
    logic [COORD_W-1:0] min_q, min_d;
    logic [COORD_W-1:0] max_q, max_d;

    always_comb begin
        cnt_d = cnt_q;
        min_d = min_q;
        max_d = max_q;
        if (clr_i) begin
            cnt_d = '0;
            min_d = '1;
            max_d = '0;
        end else if (en_i) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + COORD_W'(1);
            end
            if (hcount_i < min_q) begin
                min_d = hcount_i;
            end
            if (hcount_i > max_q) begin
                max_d = hcount_i;
            end
        end
    end

    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            min_q <= '1;
            max_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_o  = min_q;
    assign max_o  = max_q;
    assign qual_o = (cnt_q >= c_ROW_MIN);

endmodule
`default_nettype wire

// File: rtl/lpr_boundary_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lpr_boundary_detect : per-frame plate bounding box from binarized pixels   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lpr_boundary_detect
    import lpr_pkg::*;
#(
    parameter int   ROW_MIN     = 20,
    parameter int   MIN_W       = 32,
    parameter int   MIN_H       = 8,
    parameter int   HOLD_FRAMES = 2,
    parameter logic VS_POL      = 1'b1
)
(
    input  logic               pixelclk,
    input  logic               reset,
    input  logic               i_bin,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic               i_de,
    input  logic [COORD_W-1:0] hcount,
    input  logic [COORD_W-1:0] vcount,
    output logic [COORD_W-1:0] hcount_l,
    output logic [COORD_W-1:0] hcount_r,
    output logic [COORD_W-1:0] vcount_l,
    output logic [COORD_W-1:0] vcount_r,
    output logic               o_found,
    output logic               o_frame_done
);

    localparam int                 MISS_W     = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [MISS_W-1:0]  c_MISS_LIM = MISS_W'(HOLD_FRAMES - 1);
    localparam logic [COORD_W:0]   c_MIN_W    = (COORD_W+1)'(MIN_W);
    localparam logic [COORD_W:0]   c_MIN_H    = (COORD_W+1)'(MIN_H);

    state_e             state_q;
    logic               vs_q;
    logic               de_q;
    logic               vs_pend_q;
    logic [COORD_W-1:0] row_v_q;
    logic [COORD_W-1:0] h_min_q;
    logic [COORD_W-1:0] h_max_q;
    logic [COORD_W-1:0] v_top_q;
    logic [COORD_W-1:0] v_bot_q;
    logic               any_row_q;
    logic               eval_found_q;
    logic [MISS_W-1:0]  miss_q;
    box_t               box_q;
    logic               found_q;
    logic               done_q;

    logic               w_vs_edge;
    logic               w_de_fall;
    logic               w_acc_en;
    logic               w_acc_clr;
    logic [COORD_W-1:0] w_row_min;
    logic [COORD_W-1:0] w_row_max;
    logic               w_row_qual;
    logic [COORD_W:0]   w_box_w;
    logic [COORD_W:0]   w_box_h;
    logic               w_eval_found;
    logic               w_unused_hsync;

    assign w_unused_hsync = i_hsync;

    assign w_vs_edge = (vs_q != VS_POL) && (i_vsync == VS_POL);
    assign w_de_fall = de_q && !i_de;
    assign w_acc_en  = (state_q == SCAN) && i_de && i_bin;
    assign w_acc_clr = (state_q == ROW_END) || (state_q == LATCH) || (state_q == WAIT_VS);

    lpr_row_accum #(
        .ROW_MIN (ROW_MIN)
    ) u_row_accum (
        .pixelclk (pixelclk),
        .reset    (reset),
        .clr_i    (w_acc_clr),
        .en_i     (w_acc_en),
        .hcount_i (hcount),
        .min_o    (w_row_min),
        .max_o    (w_row_max),
        .qual_o   (w_row_qual)
    );

    // One extra bit keeps an empty frame (h_max < h_min) from wrapping into a small width.
    assign w_box_w      = {1'b0, h_max_q} - {1'b0, h_min_q} + (COORD_W+1)'(1);
    assign w_box_h      = {1'b0, v_bot_q} - {1'b0, v_top_q} + (COORD_W+1)'(1);
    assign w_eval_found = any_row_q && (w_box_w >= c_MIN_W) && (w_box_h >= c_MIN_H);

    always_ff @(posedge pixelclk or posedge reset) begin
        if (reset) begin
            state_q      <= WAIT_VS;
            vs_q         <= VS_POL;
            de_q         <= 1'b0;
            vs_pend_q    <= 1'b0;
            row_v_q      <= '0;
            h_min_q      <= '1;
            h_max_q      <= '0;
            v_top_q      <= '0;
            v_bot_q      <= '0;
            any_row_q    <= 1'b0;
            eval_found_q <= 1'b0;
            miss_q       <= '0;
            box_q        <= BOX_CLEAR;
            found_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            vs_q   <= i_vsync;
            de_q   <= i_de;
            done_q <= 1'b0;
            // Holding through the DE-low cycle keeps the last active line's number.
            if (i_de) begin
                row_v_q <= vcount;
            end
            case (state_q)
                WAIT_VS: begin
                    h_min_q   <= '1;
                    h_max_q   <= '0;
                    any_row_q <= 1'b0;
                    vs_pend_q <= 1'b0;
                    if (w_vs_edge) begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_de_fall) begin
                        state_q   <= ROW_END;
                        vs_pend_q <= w_vs_edge;
                    end else if (w_vs_edge) begin
                        state_q <= FRAME_EVAL;
                    end
                end
                ROW_END: begin
                    if (w_row_qual) begin
                        if (w_row_min < h_min_q) begin
                            h_min_q <= w_row_min;
                        end
                        if (w_row_max > h_max_q) begin
                            h_max_q <= w_row_max;
                        end
                        if (!any_row_q) begin
                            v_top_q <= row_v_q;
                        end
                        v_bot_q   <= row_v_q;
                        any_row_q <= 1'b1;
                    end
                    vs_pend_q <= 1'b0;
                    state_q   <= (vs_pend_q || w_vs_edge) ? FRAME_EVAL : SCAN;
                end
                FRAME_EVAL: begin
                    eval_found_q <= w_eval_found;
                    state_q      <= LATCH;
                end
                LATCH: begin
                    if (eval_found_q) begin
                        box_q   <= '{h_l: h_min_q, h_r: h_max_q, v_l: v_top_q, v_r: v_bot_q};
                        found_q <= 1'b1;
                        miss_q  <= '0;
                    end else if (miss_q < c_MISS_LIM) begin
                        miss_q <= miss_q + MISS_W'(1);
                    end else begin
                        box_q   <= BOX_CLEAR;
                        found_q <= 1'b0;
                    end
                    done_q    <= 1'b1;
                    h_min_q   <= '1;
                    h_max_q   <= '0;
                    any_row_q <= 1'b0;
                    state_q   <= SCAN;
                end
                default: begin
                    state_q <= WAIT_VS;
                end
            endcase
        end
    end

    assign hcount_l     = box_q.h_l;
    assign hcount_r     = box_q.h_r;
    assign vcount_l     = box_q.v_l;
    assign vcount_r     = box_q.v_r;
    assign o_found      = found_q;
    assign o_frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lpr_boundary_detect.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_lpr_boundary_detect : scoreboard bench for the plate boundary detector  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lpr_boundary_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bin = 1'b0;
    logic        hs  = 1'b0;
    logic        vs  = 1'b0;
    logic        de  = 1'b0;
    logic [11:0] hc  = '0;
    logic [11:0] vc  = '0;
    logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
    logic        o_found, o_frame_done;

    typedef struct {
        logic [11:0] hl;
        logic [11:0] hr;
        logic [11:0] vl;
        logic [11:0] vr;
        logic        f;
        int          t0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   t_vs     = 0;
    logic prev_done = 1'b0;

    lpr_boundary_detect u_dut (
        .pixelclk     (clk),
        .reset        (rst),
        .i_bin        (bin),
        .i_hsync      (hs),
        .i_vsync      (vs),
        .i_de         (de),
        .hcount       (hc),
        .vcount       (vc),
        .hcount_l     (hcount_l),
        .hcount_r     (hcount_r),
        .vcount_l     (vcount_l),
        .vcount_r     (vcount_r),
        .o_found      (o_found),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (prev_done) check("done_pulse_width", 64'(o_frame_done), 64'(0));
        if (o_frame_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("hcount_l", 64'(hcount_l), 64'(e.hl));
                check("hcount_r", 64'(hcount_r), 64'(e.hr));
                check("vcount_l", 64'(vcount_l), 64'(e.vl));
                check("vcount_r", 64'(vcount_r), 64'(e.vr));
                check("o_found",  64'(o_found),  64'(e.f));
                check("latency",  64'(cyc - e.t0), 64'(e.lat));
            end
        end
        prev_done = o_frame_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One line: DE spans the candidate run plus a 2-pixel non-candidate margin.
    task automatic drive_line(input int v, input int b_lo, input int b_hi, input bit vs_end);
        int lo;
        lo = (b_lo >= 2) ? b_lo - 2 : 0;
        for (int h = lo; h <= b_hi + 2; h++) begin
            tick();
            hs  = 1'b0;
            de  = 1'b1;
            hc  = 12'(h);
            vc  = 12'(v);
            bin = (h >= b_lo) && (h <= b_hi);
        end
        tick();
        de  = 1'b0;
        bin = 1'b0;
        hs  = 1'b1;
        hc  = '0;
        vc  = 12'(v + 1);
        if (vs_end) begin
            vs   = 1'b1;
            t_vs = cyc;
        end
        tick();
        tick();
    endtask

    task automatic drive_rect(input int v0, input int v1, input int h0, input int h1, input bit vs_last);
        for (int v = v0; v <= v1; v++) begin
            drive_line(v, h0, h1, vs_last && (v == v1));
        end
    endtask

    task automatic vs_edge();
        tick();
        vs   = 1'b1;
        t_vs = cyc;
    endtask

    task automatic expect_frame(input int hl, input int hr, input int vl, input int vr,
                                input bit f, input int lat);
        exp_t e;
        e.hl = 12'(hl); e.hr = 12'(hr); e.vl = 12'(vl); e.vr = 12'(vr);
        e.f = f; e.t0 = t_vs; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic drain();
        repeat (3) tick();
        vs = 1'b0;
        for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'({hcount_l, hcount_r, vcount_l, vcount_r, o_found, o_frame_done}), 64'(0));

        // Partial frame before the first vsync edge is discarded.
        drive_rect(30, 32, 10, 60, 1'b0);
        vs_edge(); drain();

        // A: reference rectangle.
        drive_rect(200, 259, 100, 299, 1'b0);
        vs_edge(); expect_frame(100, 299, 200, 259, 1'b1, 3); drain();

        // B: same rectangle with short noise lines above and below.
        drive_line(50, 10, 14, 1'b0);
        drive_rect(200, 259, 100, 299, 1'b0);
        drive_line(400, 500, 504, 1'b0);
        vs_edge(); expect_frame(100, 299, 200, 259, 1'b1, 3); drain();

        // R: reset mid-frame; remainder and its vsync edge produce nothing.
        drive_rect(5, 8, 20, 200, 1'b0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs", 64'({hcount_l, hcount_r, vcount_l, vcount_r, o_found, o_frame_done}), 64'(0));
        tick();
        rst = 1'b0;
        drive_rect(9, 12, 20, 200, 1'b0);
        vs_edge(); drain();

        // G: full frame after reset.
        drive_rect(10, 30, 40, 90, 1'b0);
        vs_edge(); expect_frame(40, 90, 10, 30, 1'b1, 3); drain();

        // C: first empty frame keeps the box; D: second clears it.
        drive_line(60, 300, 302, 1'b0);
        vs_edge(); expect_frame(40, 90, 10, 30, 1'b1, 3); drain();
        vs_edge(); expect_frame(0, 0, 0, 0, 1'b0, 3); drain();

        // F: width exactly MIN_W, a 19-pixel line ignored, a 20-pixel line qualifies.
        drive_line(5, 0, 18, 1'b0);
        drive_rect(10, 17, 40, 71, 1'b0);
        drive_line(20, 45, 64, 1'b0);
        vs_edge(); expect_frame(40, 71, 10, 20, 1'b1, 3); drain();

        // E: too short (5 lines) -> previous box held.
        drive_rect(10, 14, 50, 249, 1'b0);
        vs_edge(); expect_frame(40, 71, 10, 20, 1'b1, 3); drain();

        // X: one column narrower than MIN_W -> cleared.
        drive_rect(10, 17, 40, 70, 1'b0);
        vs_edge(); expect_frame(0, 0, 0, 0, 1'b0, 3); drain();

        // H: last line's DE fall coincides with the vsync edge.
        drive_rect(100, 120, 300, 350, 1'b1);
        expect_frame(300, 350, 100, 120, 1'b1, 4); drain();

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
